// File: rtl/chunked_rca_seq_if.sv
// chunked_rca_seq_if: operand/result valid-ready bundle for the sliced adder.
interface chunked_rca_seq_if #(parameter int N = 16);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    modport master (output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf);
    modport slave  (input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/chunked_rca_seq.sv
// chunked_rca_seq: multi-cycle ripple-carry add/sub, W bits per clock over N-bit operands.
// Optional macro RCA_SAT_EN clamps the result to the signed limit on overflow.
module chunked_rca_seq #(
    parameter int N = 16,
    parameter int W = 4
) (
    input logic clk,
    input logic rst_n,
    chunked_rca_seq_if.slave bus
);
    localparam int K  = N / W;
    localparam int CW = K > 1 ? $clog2(K) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;
    logic [N-1:0] op_a, op_b, sum;
    logic [CW-1:0] cnt;
    logic carry, cout, ovf, last, v;
    logic [W-1:0] sa, sb;
    logic [W:0] slice;
    always_comb begin
        sa    = op_a[cnt*W +: W];
        sb    = op_b[cnt*W +: W];
        slice = {1'b0, sa} + {1'b0, sb} + {{W{1'b0}}, carry};
        last  = cnt == CW'(K - 1);
        // carry into the slice MSB is recovered from its sum bit: s = a ^ b ^ c
        v     = slice[W] ^ slice[W-1] ^ sa[W-1] ^ sb[W-1];
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.in_valid ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            DONE:    nxt = bus.out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.in_valid) begin
                op_a  <= bus.a;
                op_b  <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.cin ^ bus.sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                sum[cnt*W +: W] <= slice[W-1:0];
                carry <= slice[W];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    cout <= slice[W];
                    ovf  <= v;
`ifdef RCA_SAT_EN
                    if (v) sum <= op_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
                end
            end
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = sum;
    assign bus.cout      = cout;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_chunked_rca_seq.sv
// tb_chunked_rca_seq: directed vectors for the N=16, W=4 sliced adder/subtractor.
module tb_chunked_rca_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    chunked_rca_seq_if #(.N(16)) bus ();
    chunked_rca_seq #(.N(16), .W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        bus.a = a;
        bus.b = b;
        bus.cin = ci;
        bus.sub = sb;
        bus.in_valid = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        chk({tag, " in_ready"}, bus.in_ready, 1);
        drive(a, b, ci, sb);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus.in_valid = 1'b0;
            chk({tag, " early out_valid"}, bus.out_valid, 0);
        end
        @(negedge clk);
        chk({tag, " out_valid"}, bus.out_valid, 1);
        chk({tag, " sum"}, bus.sum, es);
        chk({tag, " cout"}, bus.cout, ec);
        chk({tag, " ovf"}, bus.ovf, eo);
        chk({tag, " busy in_ready"}, bus.in_ready, 0);
        @(negedge clk);
        chk({tag, " idle out_valid"}, bus.out_valid, 0);
        chk({tag, " idle in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset sum", bus.sum, 16'h0000);
        chk("reset cout", bus.cout, 0);
        chk("reset ovf", bus.ovf, 0);
        rst_n = 1'b1;

        run_op("add basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        run_op("add ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef RCA_SAT_EN
        run_op("add pos ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("sub neg ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        run_op("add pos ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub neg ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
        run_op("sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub cin", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

        // backpressure: hold DONE with a new request pending
        @(negedge clk);
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(16'h0001, 16'h0002, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold out_valid", bus.out_valid, 1);
            chk("hold sum", bus.sum, 16'h2345);
            chk("hold cout", bus.cout, 0);
            chk("hold ovf", bus.ovf, 0);
            chk("hold in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release out_valid", bus.out_valid, 0);
        chk("release in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("reaccept in_ready", bus.in_ready, 0);
        repeat (3) @(negedge clk);
        chk("reaccept not yet done", bus.out_valid, 0);
        @(negedge clk);
        chk("reaccept out_valid", bus.out_valid, 1);
        chk("reaccept sum", bus.sum, 16'h0003);
        @(negedge clk);

        // reset mid-RUN on slice 2, after a result with cout=1 was left behind
        run_op("pre reset", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
        @(negedge clk);
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun rst out_valid", bus.out_valid, 0);
        chk("midrun rst in_ready", bus.in_ready, 1);
        chk("midrun rst sum", bus.sum, 16'h0000);
        chk("midrun rst cout", bus.cout, 0);
        chk("midrun rst ovf", bus.ovf, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no stale result", bus.out_valid, 0);
        end
        run_op("post reset", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chunked_rca_seq.md
Name: chunked_rca_seq

Overview:
Parametrised multi-cycle ripple-carry adder/subtractor. It processes N-bit operands W bits per clock, carrying between slices through a carry register. This trades latency for a short carry chain.
Valid/ready handshake on both input and output, so it drops into pipelined datapaths wherever a wide combinational ripple adder would miss timing.
Reports carry-out and signed overflow.

Parameters:
N, 16, operand and result width in bits
W, 4, slice width added per cycle; N % W must be 0; K = N/W slices

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
a  input  N  operand A
b  input  N  operand B
cin  input  1  carry-in (borrow-in when sub=1)
sub  input  1  0: a+b+cin, 1: a-b-cin
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  N  result, two's-complement wrap
cout  output  1  carry out of bit N-1; in subtract mode 1 means no borrow
ovf  output  1  signed overflow: carry into MSB xor carry out of MSB

Behaviour:
- One clock, reset synchronous active-low on clk. All outputs registered or decoded from state.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, slice counter=0, carry reg=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch a into op_a; latch (sub ? ~b : b) into op_b; carry reg <= cin ^ sub; counter <= 0; go to RUN.
- State RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle: {c, s} = op_a[i*W +: W] + op_b[i*W +: W] + carry; sum[i*W +: W] <= s; carry <= c; i <= i+1.
  - On slice K-1: capture cout = carry out of bit N-1 and ovf = carry into bit N-1 xor cout; go to DONE.
- State DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready=1: go to IDLE. in_ready returns to 1 the following cycle; no same-cycle re-accept.
- Latency: out_valid rises exactly K cycles after the accepting edge. Minimum initiation interval is K+2 cycles with out_ready tied high.
- W==N gives K=1: a single RUN cycle, with no change to the rules above.
- The sum register is partially updated during RUN. It is meaningful only while out_valid=1.
- rst_n low in any state, including mid-RUN or DONE: the operation is aborted, no result is produced, and all reset values apply on the next edge.
- out_ready while not in DONE has no effect.
- in_valid held across DONE→IDLE is accepted on the first IDLE cycle.

Optional Feature:
RCA_SAT_EN
- Defined:
  - On transition to DONE with ovf=1, sum is clamped to a signed saturation value.
  - Positive overflow (operand sign bits 0) gives 0x7FF…F; negative overflow gives 0x800…0.
  - ovf and cout are still reported unchanged. No added latency, no port change.
- Undefined: sum wraps modulo 2^N.

Test Plan:
- N=16, W=4, a=0x1234, b=0x1111, cin=0, sub=0 -> sum=0x2345, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> carry ripples through all 4 slices: sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1 (RCA_SAT_EN: sum=0x7FFF, ovf=1). Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1 (RCA_SAT_EN: 0x8000).
- a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Also a=0x0010, b=0x0003, cin=1, sub=1 -> sum=0x000C, cout=1.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum/cout/ovf stable, in_ready=0. The new operands are accepted only on the first IDLE cycle after the out handshake.
- Assert rst_n=0 for one cycle while on slice 2 of RUN -> next cycle out_valid=0, in_ready=1, sum=0, cout=0, ovf=0. No stale result appears afterwards.
